// File: rtl/pipe_ctrl.sv
// Hazard/flush sequencer for the 5-stage core: drives stall/flush of PC, IF/ID and ID/EX
// from load-use, mul/div occupancy, EX redirects and fetch-not-ready conditions.
module pipe_ctrl #(
  parameter int PC_WIDTH     = 32,
  parameter int RA_WIDTH     = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  input  logic [RA_WIDTH-1:0]  id_rs1_i,
  input  logic [RA_WIDTH-1:0]  id_rs2_i,
  input  logic                 id_rs1_re_i,
  input  logic                 id_rs2_re_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_is_load_i,
  input  logic [RA_WIDTH-1:0]  ex_rd_i,
  input  logic                 ex_rd_we_i,
  input  logic                 ex_md_start_i,
  input  logic                 md_done_i,
  input  logic                 ex_redirect_i,
  input  logic [PC_WIDTH-1:0]  ex_redirect_pc_i,
  input  logic                 if_instr_valid_i,
  output logic                 pc_stall_o,
  output logic                 if_id_stall_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_stall_o,
  output logic                 id_ex_flush_o,
  output logic                 pc_redirect_o,
  output logic [PC_WIDTH-1:0]  pc_redirect_addr_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {RUN, MD_WAIT, REDIR} state_t;

  localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_t               state_q, state_d;
  logic [2:0]           fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  logic [RA_WIDTH-1:0] id_rs    [2];
  logic [1:0]          id_rs_re;
  logic [1:0]          src_hit;
  logic                load_use;
  logic                redirect;

  assign id_rs[0]    = id_rs1_i;
  assign id_rs[1]    = id_rs2_i;
  assign id_rs_re[0] = id_rs1_re_i;
  assign id_rs_re[1] = id_rs2_re_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = id_rs_re[gi] & (id_rs[gi] == ex_rd_i);
    end
  endgenerate

  assign load_use = ex_valid_i & ex_is_load_i & ex_rd_we_i & (ex_rd_i != '0) &
                    id_valid_i & (|src_hit);
  assign redirect = ex_valid_i & ex_redirect_i;

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pc_stall_o    = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_stall_o = 1'b0;
    id_ex_flush_o = 1'b0;
    pc_redirect_o = 1'b0;

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_redirect_o = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          if (MULTI_FLUSH) begin
            state_d = REDIR;
            fcnt_d  = FCNT_RELOAD;
          end
        end else if (ex_md_start_i && !md_done_i) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          state_d       = MD_WAIT;
        end else if (load_use) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (!if_instr_valid_i) begin
          pc_stall_o    = 1'b1;
          if_id_flush_o = 1'b1;
        end
      end
      MD_WAIT: begin
        if (!md_done_i) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      REDIR: begin
        // Fetch data in flight is wrong-path; ID/EX already holds bubbles.
        if_id_flush_o = 1'b1;
        if (redirect) begin
          pc_redirect_o = 1'b1;
          id_ex_flush_o = 1'b1;
          fcnt_d        = FCNT_RELOAD;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q == 3'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_stall_o    = 1'b0;
      if_id_stall_o = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_stall_o = 1'b0;
      id_ex_flush_o = 1'b0;
      pc_redirect_o = 1'b0;
    end
  end

  assign pc_redirect_addr_o = rst ? '0 : ex_redirect_pc_i;
  assign stall_cycles_o     = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (pc_stall_o && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and flush sequencer for the 5-stage core. It drives the stall and flush controls of the PC register, the IF/ID register and the ID/EX register. It covers load-use hazards, multi-cycle mul/div occupancy of EX, taken-branch/jump redirects with a configurable fetch-flush window, and fetch-not-ready bubbles. It sits beside the datapath and observes decode and execute; it holds no instruction data itself.

## Interface
Parameters:
- PC_WIDTH, 32, program counter width
- RA_WIDTH, 5, register address width
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after a redirect (legal 1..7)
- CNT_WIDTH, 32, stall-cycle counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_i / id_rs2_i  in  RA_WIDTH  ID source registers
- id_rs1_re_i / id_rs2_re_i  in  1  source register actually read
- ex_valid_i  in  1  EX holds a valid instruction
- ex_is_load_i  in  1  EX instruction is a load
- ex_rd_i  in  RA_WIDTH  EX destination register
- ex_rd_we_i  in  1  EX writes rd
- ex_md_start_i  in  1  mul/div instruction entered EX this cycle
- md_done_i  in  1  mul/div unit result valid this cycle
- ex_redirect_i  in  1  EX resolved a taken branch/jump
- ex_redirect_pc_i  in  PC_WIDTH  redirect target
- if_instr_valid_i  in  1  fetch data valid this cycle
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF/ID register
- if_id_flush_o  out  1  load bubble into IF/ID
- id_ex_stall_o  out  1  hold ID/EX register
- id_ex_flush_o  out  1  load bubble into ID/EX
- pc_redirect_o  out  1  load PC with pc_redirect_addr_o
- pc_redirect_addr_o  out  PC_WIDTH  redirect target (pass-through of ex_redirect_pc_i)
- stall_cycles_o  out  CNT_WIDTH  saturating count of cycles with pc_stall_o=1

## Operation
- States: RUN, MD_WAIT, REDIR. There is a 3-bit flush counter fcnt.
- Control outputs are combinational from the registered state and the current inputs. Stall takes precedence over flush on the same register; this never co-occurs by construction.
- load_use = ex_valid_i & ex_is_load_i & ex_rd_we_i & (ex_rd_i!=0) & id_valid_i & ((id_rs1_re_i & id_rs1_i==ex_rd_i) | (id_rs2_re_i & id_rs2_i==ex_rd_i)).
- RUN, evaluated in priority order:
  1. ex_valid_i & ex_redirect_i: pc_redirect_o=1, if_id_flush_o=1, id_ex_flush_o=1. If FLUSH_CYCLES>1, go to REDIR with fcnt=FLUSH_CYCLES-1; else stay in RUN.
  2. ex_md_start_i & !md_done_i: pc_stall_o, if_id_stall_o and id_ex_stall_o =1; go to MD_WAIT.
  3. load_use: pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1 (one bubble); stay in RUN.
  4. !if_instr_valid_i: pc_stall_o=1, if_id_flush_o=1; stay in RUN.
  5. Otherwise all outputs are 0.
  - ex_md_start_i & md_done_i in the same cycle is a single-cycle op: no stall.
- MD_WAIT:
  - While !md_done_i: pc_stall_o, if_id_stall_o and id_ex_stall_o =1.
  - On md_done_i: all outputs 0; go to RUN.
  - ex_redirect_i, load_use and fetch-not-ready are ignored.
- REDIR:
  - if_id_flush_o=1 every cycle (discards wrong-path fetch data). fcnt decrements; go to RUN when fcnt==1.
  - A new ex_valid_i & ex_redirect_i re-issues the redirect (pc_redirect_o=1, both flushes) and reloads fcnt=FLUSH_CYCLES-1.
  - load_use and md start are ignored, because ID/EX hold bubbles.
- stall_cycles_o increments by 1 in each cycle with pc_stall_o=1 and saturates at all-ones.

## Timing
- Reset (rst=1 sampled at an edge): state=RUN, fcnt=0, stall_cycles_o=0.
  - While rst=1, all control outputs are forced to 0 and pc_redirect_addr_o=0.
  - Reset mid-MD_WAIT or mid-REDIR aborts to RUN on the next edge.
- Load-use costs exactly 1 stall cycle. The next cycle the load is in MEM, so load_use is deasserted.
- Mul/div of N cycles (md_done_i N cycles after start) costs N stall cycles.
- A redirect costs FLUSH_CYCLES+1 bubbles in ID: the redirect cycle plus FLUSH_CYCLES-1 REDIR cycles, plus the naturally flushed ID slot.
- pc_redirect_o is a single-cycle pulse per accepted redirect.

## Test plan
- Load-use: EX lw x5 (ex_rd_i=5), ID add reading rs1=5 -> exactly 1 cycle of pc_stall/if_id_stall/id_ex_flush=1; stall_cycles_o=1. Same case with ex_rd_i=0 -> no stall.
- Mul/div: ex_md_start_i with md_done_i 4 cycles later -> 4 cycles of triple stall, state returns to RUN, stall_cycles_o=4. Same-cycle done -> no stall.
- Redirect, FLUSH_CYCLES=3, target 0x0000_0100 -> pc_redirect_o one pulse with addr 0x100, then if_id_flush_o=1 for 2 more cycles. A concurrent load_use in the redirect cycle is suppressed.
- Back-to-back redirect during REDIR -> second pulse issued and fcnt reloaded to 2.
- if_instr_valid_i=0 for 3 cycles in RUN -> pc_stall_o=1 and if_id_flush_o=1 for 3 cycles.
- rst=1 asserted in cycle 2 of MD_WAIT -> outputs 0 immediately, RUN and stall_cycles_o=0 after the edge. Counter with CNT_WIDTH=4 saturates at 15.
